fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the ARM pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register.
- Handles hazard freeze, branch redirect (with flush of the wrong-path fetch), and keeps fetch/stall performance counters.
- Sits between the hazard/branch logic in EX and the ID stage.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'hE1A0_0000, word written into the IF/ID register on flush or reset (MOV r0,r0).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- freeze  in  1  hazard stall; hold PC and the IF/ID register.
- branch_taken  in  1  redirect request from EX; flushes IF/ID.
- branch_addr  in  32  branch target byte address.
- imem_addr  out  32  byte address to instruction memory; equals pc (combinational).
- imem_rdata  in  32  instruction word from memory; combinational, same cycle as imem_addr.
- if_id_valid  out  1  IF/ID register holds a real instruction.
- if_id_pc  out  32  address of the IF/ID instruction + 4.
- if_id_instr  out  32  IF/ID instruction word.
- fetch_count  out  CNT_W  number of instructions captured into IF/ID.
- stall_count  out  CNT_W  number of cycles with freeze=1 and branch_taken=0.

Behaviour:
- Reset values, taking effect at the first rising edge with rst=1:
  - pc=PC_RESET, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, both counters=0.
  - rst overrides every other input, including mid-stall and mid-branch.
- Priority on each edge with rst=0: branch_taken > freeze > normal.
- Branch (branch_taken=1, freeze ignored):
  - pc <= {branch_addr[31:2],2'b00}; bits [1:0] of branch_addr are silently dropped.
  - IF/ID flushed: valid=0, instr=NOP_INSTR, if_id_pc=0.
  - The word at the target is fetched on the following cycle, so the branch penalty is one bubble from this stage.
- Freeze (freeze=1, branch_taken=0):
  - pc, if_id_valid, if_id_pc and if_id_instr all hold.
  - imem_addr stays constant; the memory read repeats.
  - stall_count increments.
- Normal (both inputs 0):
  - pc <= pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - IF/ID captures: valid=1, if_id_pc=pc+4, if_id_instr=imem_rdata.
  - fetch_count increments.
- Latency: a word addressed in cycle N appears on if_id_* after the edge ending cycle N.
- The stage is fully pipelined: one instruction per cycle when not frozen.
- Counters wrap at 2^CNT_W without saturation; no other flag is raised.
- pc[1:0] is 0 by construction; imem_addr is always word-aligned.
- No internal state depends on imem_rdata other than the captured word; X on imem_rdata during a flush or freeze must not propagate.

Decomposition:
- Shared package arm_pkg holds:
  - localparams WORD_W=32, INSTR_BYTES=4, NOP_INSTR default.
  - typedef word_t (logic [31:0]).
  - struct if_id_t {valid, pc, instr} for reuse by the ID stage.
- One natural sub-module: if_id_reg.
  - Contains the IF/ID pipeline register with rst/flush/freeze/load controls.
  - Reused as the template for the later ID/EX, EX/MEM and MEM/WB registers.
- The PC register, next-PC mux and counters remain in fetch_stage.

Test Plan:
- Sequential fetch:
  - Stimulus: rst for 2 cycles, then 4 free-running cycles with imem_rdata = 32'h1111_0000 + imem_addr.
  - Required: imem_addr steps 0,4,8,C; if_id_pc is 4,8,C,10; if_id_instr is 32'h1111_0000, 32'h1111_0004, and so on; fetch_count=4.
- Freeze:
  - Stimulus: freeze=1 for 3 cycles with pc=8.
  - Required: imem_addr stays 8 and the IF/ID register is unchanged throughout; stall_count=3; after release, IF/ID gets the word at 8 with if_id_pc=C.
- Branch with flush:
  - Stimulus: branch_taken=1, branch_addr=32'h0000_0043, at pc=C.
  - Required: next cycle imem_addr=32'h40, if_id_valid=0, if_id_instr=32'hE1A0_0000; the following edge captures the word at 40 with if_id_pc=44.
- Simultaneous branch and freeze:
  - Stimulus: both inputs high for one cycle.
  - Required: branch wins; pc=target, IF/ID flushed, stall_count unchanged.
- PC wrap:
  - Stimulus: branch to 32'hFFFF_FFFC, then one normal cycle.
  - Required: imem_addr wraps to 0 and if_id_pc=0.
- Reset mid-operation:
  - Stimulus: assert rst while freeze=1 and the counters are nonzero.
  - Required: after the edge, pc=PC_RESET, if_id_valid=0, both counters=0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants used by the fetch stage and later stages.
package arm_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [WORD_W-1:0] word_t;

    // MOV r0,r0: the bubble instruction placed in pipeline registers
    localparam word_t ARM_NOP = 32'hE1A0_0000;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with reset, flush, freeze and load controls.
module if_id_reg
    import arm_pkg::*;
#(
    parameter word_t NOP_INSTR = ARM_NOP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   freeze,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // Priority: rst/flush insert a bubble, freeze holds, load captures
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q.valid <= 1'b0;
            q.pc    <= '0;
            q.instr <= NOP_INSTR;
        end else if (!freeze && load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture and perf counters.
module fetch_stage
    import arm_pkg::*;
#(
    parameter word_t       PC_RESET  = 32'h0000_0000,
    parameter word_t       NOP_INSTR = ARM_NOP,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             if_id_valid,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam word_t PC_STEP    = word_t'(INSTR_BYTES);
    localparam word_t ALIGN_MASK = ~word_t'(INSTR_BYTES - 1);

    word_t  pc;
    word_t  pc_inc_c;
    if_id_t cap_c;
    if_id_t if_id_q;
    logic   advance_c;
    logic   stall_c;

    assign pc_inc_c  = pc + PC_STEP;
    assign advance_c = !branch_taken && !freeze;
    assign stall_c   = !branch_taken && freeze;
    assign imem_addr = pc;

    always_comb begin
        cap_c       = '0;
        cap_c.valid = 1'b1;
        cap_c.pc    = pc_inc_c;
        cap_c.instr = imem_rdata;
    end

    // Branch beats freeze; target low bits are dropped to keep pc word-aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_RESET & ALIGN_MASK;
        end else if (branch_taken) begin
            pc <= branch_addr & ALIGN_MASK;
        end else if (!freeze) begin
            pc <= pc_inc_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (advance_c) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (stall_c) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_taken),
        .freeze(freeze),
        .load  (1'b1),
        .d     (cap_c),
        .q     (if_id_q)
    );

    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    logic [31:0] salt = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (32'h1111_0000 + a) ^ salt;
    endfunction

    // Instruction memory: combinational read
    always_comb imem_rdata = mem_word(imem_addr);

    // Behavioural model of the stage, advanced on each rising edge
    logic [31:0] m_pc, m_ipc, m_instr, m_fc, m_sc;
    logic        m_valid;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
            m_fc = 32'h0; m_sc = 32'h0; m_known = 1'b1;
        end else if (m_known) begin
            if (branch_taken) begin
                m_pc = {branch_addr[31:2], 2'b00};
                m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
            end else if (freeze) begin
                m_sc = m_sc + 1;
            end else begin
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_ipc = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
                m_fc = m_fc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_valid", 32'(if_id_valid), 32'(m_valid));
            chk("m_if_id_pc", if_id_pc, m_ipc);
            chk("m_if_id_instr", if_id_instr, m_instr);
            chk("m_fetch_count", fetch_count, m_fc);
            chk("m_stall_count", stall_count, m_sc);
        end
    end

    // Apply inputs for one cycle, then return just after the following falling edge
    task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] a);
        rst = r; freeze = f; branch_taken = b; branch_addr = a;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_ipc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_fc", fetch_count, 32'h0);
        chk("rst_sc", stall_count, 32'h0);

        // Sequential fetch
        cyc(0, 0, 0, 0);
        chk("seq_addr1", imem_addr, 32'h4);
        chk("seq_ipc1", if_id_pc, 32'h4);
        chk("seq_instr1", if_id_instr, 32'h1111_0000);
        cyc(0, 0, 0, 0);
        chk("seq_addr2", imem_addr, 32'h8);
        chk("seq_instr2", if_id_instr, 32'h1111_0004);

        // Freeze at pc=8 for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("frz_addr", imem_addr, 32'h8);
            chk("frz_ipc", if_id_pc, 32'h8);
            chk("frz_instr", if_id_instr, 32'h1111_0004);
        end
        chk("frz_sc", stall_count, 32'd3);
        cyc(0, 0, 0, 0);
        chk("rel_ipc", if_id_pc, 32'hC);
        chk("rel_instr", if_id_instr, 32'h1111_0008);
        cyc(0, 0, 0, 0);
        chk("seq_fc4", fetch_count, 32'd4);
        chk("seq_ipc4", if_id_pc, 32'h10);

        // Branch with flush from pc=C
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("br_pre_pc", imem_addr, 32'hC);
        cyc(0, 0, 1, 32'h0000_0043);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_valid", 32'(if_id_valid), 32'h0);
        chk("br_instr", if_id_instr, NOP);
        chk("br_ipc", if_id_pc, 32'h0);
        cyc(0, 0, 0, 0);
        chk("br_tgt_ipc", if_id_pc, 32'h44);
        chk("br_tgt_instr", if_id_instr, 32'h1111_0040);

        // Branch and freeze together: branch wins, no stall counted
        cyc(0, 1, 1, 32'h0000_0100);
        chk("bf_addr", imem_addr, 32'h100);
        chk("bf_valid", 32'(if_id_valid), 32'h0);
        chk("bf_sc", stall_count, 32'h0);

        // PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ipc", if_id_pc, 32'h0);
        chk("wrap_instr", if_id_instr, 32'h1110_FFFC);

        // Reset while frozen with nonzero counters
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("mid_sc", stall_count, 32'd2);
        cyc(1, 1, 0, 0);
        chk("mid_pc", imem_addr, 32'h0);
        chk("mid_valid", 32'(if_id_valid), 32'h0);
        chk("mid_fc", fetch_count, 32'h0);
        chk("mid_sc0", stall_count, 32'h0);

        // Randomized traffic checked by the model every cycle
        salt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic r, f, b;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            cyc(r, f, b, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
